// File: rtl/autoconfig_master.sv
// autoconfig_master: Zorro II AutoConfig initiator at $E8xxxx; AUTOCONFIG_MASTER_LOW_NIBBLE_EN adds the $4A low-nibble base write
module autoconfig_master #(
  parameter logic [7:0]  BASE_START = 8'h20,
  parameter logic [7:0]  BASE_LIMIT = 8'hA0,
  parameter logic [15:0] TIMEOUT    = 16'd1023,
  parameter logic [2:0]  MAX_BOARDS = 3'd4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  output logic [22:0] o_address,
  output logic        o_as_n,
  output logic        o_uds_n,
  output logic        o_lds_n,
  output logic        o_rw,
  input  logic [3:0]  i_data_in,
  output logic [3:0]  o_data_out,
  output logic        o_data_oe,
  input  logic        i_dtack_n,
  output logic        o_busy,
  output logic        o_done,
  output logic [2:0]  o_board_count,
  output logic [2:0]  o_shutup_count,
  output logic [7:0]  o_last_base
);
`ifdef AUTOCONFIG_MASTER_LOW_NIBBLE_EN
  localparam logic LOW_NIB = 1'b1;
`else
  localparam logic LOW_NIB = 1'b0;
`endif
  typedef enum logic [3:0] {S_IDLE, S_RD_TYPE, S_RD_PROD, S_RD_FLAGS, S_RD_MFG, S_ALLOC, S_WR_BASE, S_WR_SHUT, S_NEXT, S_FINISH} state_t;
  typedef enum logic [2:0] {P_T0, P_T1, P_LATCH, P_REL, P_WAITHI} phase_t;
  state_t      r_state, w_state;
  phase_t      r_ph, w_ph;
  logic [1:0]  r_idx, w_idx, w_last_idx;
  logic        r_dt_s1, r_dt_s2;
  logic [15:0] r_tmo;
  logic [1:0]  r_zii;
  logic [2:0]  r_code;
  logic [8:0]  r_next_free;
  logic [7:0]  r_last_base;
  logic [2:0]  r_board_count, r_shutup_count;
  logic        w_bus, w_wr, w_lo, w_last, w_done_op, w_timeout, w_ok, w_full;
  logic [6:0]  w_off;
  logic [8:0]  w_size, w_align, w_base;
  assign w_bus      = r_state inside {S_RD_TYPE, S_RD_PROD, S_RD_FLAGS, S_RD_MFG, S_WR_BASE, S_WR_SHUT};
  assign w_wr       = r_state inside {S_WR_BASE, S_WR_SHUT};
  assign w_lo       = LOW_NIB & ~r_idx[0];
  assign w_last_idx = (r_state == S_RD_MFG) ? 2'd3 : (r_state == S_WR_SHUT) ? 2'd0 :
                      (r_state == S_WR_BASE) ? {1'b0, LOW_NIB} : 2'd1;
  assign w_last     = r_idx == w_last_idx;
  assign w_done_op  = w_bus && r_ph == P_WAITHI && r_dt_s2;
  assign w_timeout  = w_bus && r_ph == P_T1 && r_dt_s2 && r_tmo == TIMEOUT - 16'd1;
  assign w_size     = (r_code == 3'd0) ? 9'd128 : 9'd1 << (r_code - 3'd1);
  assign w_align    = (!LOW_NIB && w_size < 9'd16) ? 9'd16 : w_size;
  assign w_base     = (r_next_free + w_align - 9'd1) & ~(w_align - 9'd1);
  assign w_ok       = r_zii == 2'b11 && w_base + w_size <= {1'b0, BASE_LIMIT};
  assign w_full     = {1'b0, r_board_count} + {1'b0, r_shutup_count} == {1'b0, MAX_BOARDS};
  assign o_board_count  = r_board_count;
  assign o_shutup_count = r_shutup_count;
  assign o_last_base    = r_last_base;
  // State register: run state, bus phase and nibble index
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_ph    <= P_T0;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_state;
      r_ph    <= w_ph;
      r_idx   <= w_idx;
    end
  end
  // Next state: bus phase sequencing, nibble stepping, run control; a new state always starts at T0
  always_comb begin
    w_state = r_state;
    w_ph    = r_ph;
    w_idx   = r_idx;
    if (w_bus)
      case (r_ph)
        P_T0:    w_ph = P_T1;
        P_T1:    w_ph = r_dt_s2 ? P_T1 : P_LATCH;
        P_LATCH: w_ph = P_REL;
        P_REL:   w_ph = P_WAITHI;
        default: w_ph = r_dt_s2 ? P_T0 : P_WAITHI;
      endcase
    if (w_done_op) begin
      w_idx = r_idx + 2'd1;
      if (w_last) w_state = w_wr ? S_NEXT : state_t'(r_state + 4'd1);
    end
    if (w_timeout) w_state = S_FINISH;
    case (r_state)
      S_IDLE:   w_state = i_start ? S_RD_TYPE : S_IDLE;
      S_ALLOC:  w_state = w_ok ? S_WR_BASE : S_WR_SHUT;
      S_NEXT:   w_state = w_full ? S_FINISH : S_RD_TYPE;
      S_FINISH: w_state = S_IDLE;
      default:  ;
    endcase
    if (w_state != r_state) begin
      w_ph  = P_T0;
      w_idx = 2'd0;
    end
  end
  // Word offset (A7:A1) of the register addressed by the current nibble
  always_comb begin
    w_off = 7'h00;
    case (r_state)
      S_RD_TYPE:  w_off = {5'h00, r_idx};
      S_RD_PROD:  w_off = 7'h02 + {5'h00, r_idx};
      S_RD_FLAGS: w_off = 7'h04 + {5'h00, r_idx};
      S_RD_MFG:   w_off = 7'h08 + {5'h00, r_idx};
      S_WR_BASE:  w_off = 7'h24 + {6'h00, w_lo};
      S_WR_SHUT:  w_off = 7'h26;
      default:    w_off = 7'h00;
    endcase
  end
  // Bus outputs decoded from state and phase; strobes low only in T1 and the latch cycle
  always_comb begin
    o_as_n     = !(w_bus && (r_ph == P_T1 || r_ph == P_LATCH));
    o_uds_n    = o_as_n;
    o_lds_n    = 1'b1;
    o_rw       = !w_wr;
    o_data_oe  = w_wr && r_ph != P_WAITHI;
    o_data_out = (r_state == S_WR_BASE) ? (w_lo ? r_last_base[3:0] : r_last_base[7:4]) : 4'h0;
    o_address  = w_bus ? {16'hE800, w_off} : 23'h0;
    o_busy     = r_state != S_IDLE && r_state != S_FINISH;
    o_done     = r_state == S_FINISH;
  end
  // Datapath: DTACK synchroniser, timeout counter, type capture, allocator and counters
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dt_s1        <= 1'b1;
      r_dt_s2        <= 1'b1;
      r_tmo          <= 16'd0;
      r_zii          <= 2'd0;
      r_code         <= 3'd0;
      r_next_free    <= {1'b0, BASE_START};
      r_last_base    <= 8'h00;
      r_board_count  <= 3'd0;
      r_shutup_count <= 3'd0;
    end else begin
      r_dt_s1 <= i_dtack_n;
      r_dt_s2 <= r_dt_s1;
      r_tmo   <= (r_ph == P_T0) ? 16'd0 : r_tmo + 16'd1;
      if (r_state == S_RD_TYPE && r_ph == P_LATCH && r_idx[0]) r_code <= i_data_in[2:0];
      if (r_state == S_RD_TYPE && r_ph == P_LATCH && !r_idx[0]) r_zii <= i_data_in[3:2];
      if (r_state == S_IDLE && i_start) begin
        r_next_free    <= {1'b0, BASE_START};
        r_last_base    <= 8'h00;
        r_board_count  <= 3'd0;
        r_shutup_count <= 3'd0;
      end
      if (r_state == S_ALLOC && w_ok) begin
        r_next_free <= w_base + w_size;
        r_last_base <= w_base[7:0];
      end
      if (w_done_op && w_last && r_state == S_WR_BASE) r_board_count <= r_board_count + 3'd1;
      if (w_done_op && r_state == S_WR_SHUT) r_shutup_count <= r_shutup_count + 3'd1;
    end
  end
endmodule

// File: tb/tb_autoconfig_master.sv
// tb_autoconfig_master: directed AutoConfig runs against a behavioural chain of responder boards
module tb_autoconfig_master;
`ifdef AUTOCONFIG_MASTER_LOW_NIBBLE_EN
  localparam int LN = 1;
`else
  localparam int LN = 0;
`endif
  logic clk = 0, rst = 1, start0 = 0, start1 = 0, sel = 0, dtack_n = 1, inflight = 0;
  logic [22:0] a0, a1, bus_addr;
  logic as0, as1, uds0, uds1, lds0, lds1, rw0, rw1, oe0, oe1, done0, done1, busy0, busy1;
  logic [3:0] do0, do1, data_in, bus_dout;
  logic [2:0] bc0, bc1, sc0, sc1;
  logic [7:0] lb0, lb1;
  logic bus_as_n, bus_uds_n, bus_rw, bus_oe, bus_done, bus_busy;
  logic [7:0] btype [8], bprod [8];
  logic [6:0] wr_off [16], cyc_off;
  logic [3:0] wr_dat [16];
  int cur = 0, nb = 0, nw = 0, nr = 0, badhi = 0, badoe = 0, asl = 0, checks = 0, errors = 0;
  always #5 clk = ~clk;
  autoconfig_master dut0 (.i_clk(clk), .i_reset(rst), .i_start(start0), .o_address(a0), .o_as_n(as0),
    .o_uds_n(uds0), .o_lds_n(lds0), .o_rw(rw0), .i_data_in(data_in), .o_data_out(do0), .o_data_oe(oe0),
    .i_dtack_n(sel | dtack_n), .o_busy(busy0), .o_done(done0), .o_board_count(bc0),
    .o_shutup_count(sc0), .o_last_base(lb0));
  autoconfig_master #(.BASE_LIMIT(8'h28)) dut1 (.i_clk(clk), .i_reset(rst), .i_start(start1), .o_address(a1),
    .o_as_n(as1), .o_uds_n(uds1), .o_lds_n(lds1), .o_rw(rw1), .i_data_in(data_in), .o_data_out(do1),
    .o_data_oe(oe1), .i_dtack_n(!sel | dtack_n), .o_busy(busy1), .o_done(done1), .o_board_count(bc1),
    .o_shutup_count(sc1), .o_last_base(lb1));
  assign bus_addr  = sel ? a1 : a0;
  assign bus_as_n  = sel ? as1 : as0;
  assign bus_uds_n = sel ? uds1 : uds0;
  assign bus_rw    = sel ? rw1 : rw0;
  assign bus_oe    = sel ? oe1 : oe0;
  assign bus_dout  = sel ? do1 : do0;
  assign bus_done  = sel ? done1 : done0;
  assign bus_busy  = sel ? busy1 : busy0;
  function automatic logic [3:0] nib(input logic [7:0] t, input logic [7:0] p, input logic [6:0] o);
    nib = (o == 7'd0) ? t[7:4] : (o == 7'd1) ? t[3:0] : (o == 7'd2) ? ~p[7:4] : (o == 7'd3) ? ~p[3:0] : 4'hF;
  endfunction
  assign data_in = (cur < nb) ? nib(btype[cur], bprod[cur], bus_addr[6:0]) : 4'h0;
  // Responder chain: the current unconfigured board answers; a $48/$4C write passes the chain on
  always @(negedge clk) begin
    if (!bus_as_n && !bus_uds_n) begin
      if (!inflight && cur < nb) begin
        inflight = 1;
        cyc_off = bus_addr[6:0];
        if (bus_addr[22:7] != 16'hE800) badhi++;
        if (bus_rw) nr++;
        else begin
          if (!bus_oe) badoe++;
          if (nw < 16) begin
            wr_off[nw] = bus_addr[6:0];
            wr_dat[nw] = bus_dout;
          end
          nw++;
        end
      end
      if (inflight) dtack_n = 0;
    end else if (bus_as_n) begin
      if (inflight && (cyc_off == 7'h24 || cyc_off == 7'h26)) cur++;
      inflight = 0;
      dtack_n = 1;
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clear_resp(input int n);
    cur = 0; nb = n; nw = 0; nr = 0; inflight = 0; dtack_n = 1;
  endtask
  task automatic run(input logic s, input logic mid);
    logic got;
    got = 0;
    asl = 0;
    sel = s;
    @(negedge clk); start0 = !s; start1 = s;
    @(negedge clk); start0 = 0; start1 = 0;
    for (int i = 0; i < 6000 && !got; i++) begin
      @(negedge clk);
      start0 = mid && (i == 50);
      if (!bus_as_n) asl++;
      if (bus_done) got = 1;
    end
    start0 = 0;
    check("done_seen", got, 1);
    @(negedge clk);
    check("done_pulse_busy", {bus_done, bus_busy}, 0);
  endtask
  initial begin
    logic got;
    repeat (3) @(negedge clk);
    check("rst_strobes", {as0, uds0, lds0, rw0}, 4'hF);
    check("rst_oe_dout", {oe0, do0}, 0);
    check("rst_addr", a0, 0);
    check("rst_busy_done", {busy0, done0}, 0);
    check("rst_counts", {bc0, sc0, lb0}, 0);
    rst = 0;
    // 512K board: base $20, $48 data 2
    clear_resp(1); btype[0] = 8'hC4; bprod[0] = 8'h68;
    run(0, 0);
    check("b512_count", {bc0, sc0}, {3'd1, 3'd0});
    check("b512_base", lb0, 8'h20);
    check("b512_nw", nw, 1 + LN);
    check("b512_off", wr_off[LN], 7'h24);
    check("b512_dat", wr_dat[LN], 4'h2);
    check("b512_reads", nr, 10);
`ifdef AUTOCONFIG_MASTER_LOW_NIBBLE_EN
    check("b512_lo_off", wr_off[0], 7'h25);
    check("b512_lo_dat", wr_dat[0], 4'h0);
`endif
    // 512K then 1M, START pulsed mid-run must be ignored
    clear_resp(2); btype[1] = 8'hC5; bprod[1] = 8'h12;
    run(0, 1);
    check("two_count", {bc0, sc0}, {3'd2, 3'd0});
    check("two_base", lb0, 8'h30);
    check("two_nw", nw, 2 + 2 * LN);
    check("two_dat0", wr_dat[LN], 4'h2);
    check("two_off1", wr_off[1 + 2 * LN], 7'h24);
    check("two_dat1", wr_dat[1 + 2 * LN], 4'h3);
    // Bad type nibble 8 -> shut up
    clear_resp(1); btype[0] = 8'h84;
    run(0, 0);
    check("bad_count", {bc0, sc0}, {3'd0, 3'd1});
    check("bad_nw", nw, 1);
    check("bad_off", wr_off[0], 7'h26);
    check("bad_dat", wr_dat[0], 4'h0);
    check("bad_base", lb0, 8'h00);
    // 8M board cannot fit under $A0
    clear_resp(1); btype[0] = 8'hC0;
    run(0, 0);
    check("b8m_count", {bc0, sc0}, {3'd0, 3'd1});
    check("b8m_off", wr_off[0], 7'h26);
    // Limit $28: 512K fills exactly to the ceiling, following 1M overflows
    clear_resp(2); btype[0] = 8'hC4; btype[1] = 8'hC5;
    run(1, 0);
    check("lim_count", {bc1, sc1}, {3'd1, 3'd1});
    check("lim_base", lb1, 8'h20);
    check("lim_off_base", wr_off[LN], 7'h24);
    check("lim_off_shut", wr_off[1 + LN], 7'h26);
    // Five 64K boards: run stops after MAX_BOARDS without a timeout
    clear_resp(5);
    for (int i = 0; i < 5; i++) btype[i] = 8'hC1;
    run(0, 0);
    check("max_count", {bc0, sc0}, {3'd4, 3'd0});
    check("max_base", lb0, LN ? 8'h23 : 8'h50);
    check("max_reads", nr, 40);
    check("max_cur", cur, 4);
    check("max_no_timeout", asl < 500, 1);
    // Empty chain: AS_n low exactly TIMEOUT cycles
    clear_resp(0);
    run(0, 0);
    check("tmo_as_low", asl, 1023);
    check("tmo_count", {bc0, sc0}, 0);
    check("tmo_strobes", {as0, uds0}, 2'b11);
    // Reset during the second board's bus cycle
    clear_resp(2); btype[0] = 8'hC4; btype[1] = 8'hC5; sel = 0;
    @(negedge clk); start0 = 1;
    @(negedge clk); start0 = 0;
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (bc0 == 3'd1 && !as0) got = 1;
    end
    check("rst_mid_reached", got, 1);
    rst = 1;
    @(posedge clk); #1;
    check("rst_mid_strobes", {as0, uds0}, 2'b11);
    check("rst_mid_busy", busy0, 0);
    check("rst_mid_counts", {bc0, sc0, lb0}, 0);
    @(negedge clk); rst = 0;
    clear_resp(0);
    check("addr_high", badhi, 0);
    check("write_oe", badoe, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
